fencer_action_sequencer: RTL and testbench

Parametrised action sequencer for one fencer. It turns debounced gesture inputs (block, lunge) and per-cycle collision results (blade hit on opponent, saber clash, opponent hit on us) into a timed state sequence: rest, block, lunge, attack, score, recover and bout end. It also keeps a saturating bout score. It sits between the gesture/IR front end and the collision detectors on one side, and the renderer and score display on the other, all on the pixel clock.

---
 rtl/fencer_action_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fencer_action_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fencer_action_sequencer.sv
// Fencer action sequencer: gestures + collision results -> REST/BLOCK/LUNGE/ATTACK/SCORE/RECOVER/DONE, saturating bout score.
// Latency: every output is registered; state_out follows the causing input by one clock.
// Backpressure: none; inputs are sampled every cycle. Optional build macro FENCE_RIPOSTE_EN enables BLOCK->ATTACK on clash.
module fencer_action_sequencer #(
  parameter int LUNGE_CYCLES   = 4,
  parameter int ATTACK_CYCLES  = 16,
  parameter int RECOVER_CYCLES = 32,
  parameter int MAX_SCORE      = 15,
  parameter int SCORE_W        = 4
) (
  input  logic               clk_pixel_in,
  input  logic               rst_in,
  input  logic               block_in,
  input  logic               lunge_in,
  input  logic               hit_in,
  input  logic               clash_in,
  input  logic               opp_hit_in,
  input  logic               new_bout_in,
  output logic [2:0]         state_out,
  output logic               in_attack_out,
  output logic [SCORE_W-1:0] score_out,
  output logic               score_pulse_out,
  output logic               bout_over_out
);

  // The dwell counter is shared by all timed states, so it is sized for the longest dwell.
  localparam int MAX_LA    = (LUNGE_CYCLES > ATTACK_CYCLES) ? LUNGE_CYCLES : ATTACK_CYCLES;
  localparam int MAX_DWELL = (MAX_LA > RECOVER_CYCLES) ? MAX_LA : RECOVER_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL) + 1;

  // Counter starts at 0 on entry, so the last cycle of an N-cycle dwell is count N-1.
  localparam logic [CNT_W-1:0]   LUNGE_LAST   = CNT_W'(LUNGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ATTACK_LAST  = CNT_W'(ATTACK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = SCORE_W'(MAX_SCORE);

  typedef enum logic [2:0] {
    S_REST    = 3'd0,
    S_BLOCK   = 3'd1,
    S_LUNGE   = 3'd2,
    S_ATTACK  = 3'd3,
    S_SCORE   = 3'd4,
    S_RECOVER = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_next;
  logic               r_in_attack;
  logic               r_score_pulse;
  logic               r_bout_over;
  logic               w_counting;

  // Next-state selection; opponent hits pre-empt every other move while engaged.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_REST: begin
        if (block_in) begin
          w_next = S_BLOCK;
        end else if (lunge_in) begin
          w_next = S_LUNGE;
        end
      end
      S_BLOCK: begin
        if (opp_hit_in) begin
          w_next = S_RECOVER;
`ifdef FENCE_RIPOSTE_EN
        end else if (clash_in) begin
          // Riposte: a parried blade goes straight into an attack, skipping the lunge wind-up.
          w_next = S_ATTACK;
`endif
        end else if (!block_in) begin
          w_next = S_REST;
        end
      end
      S_LUNGE: begin
        if (opp_hit_in) begin
          w_next = S_RECOVER;
        end else if (r_cnt == LUNGE_LAST) begin
          w_next = S_ATTACK;
        end
      end
      S_ATTACK: begin
        // A hit on the last timed cycle still scores because hit is checked before timeout.
        if (opp_hit_in) begin
          w_next = S_RECOVER;
        end else if (hit_in) begin
          w_next = S_SCORE;
        end else if (clash_in || (r_cnt == ATTACK_LAST)) begin
          w_next = S_RECOVER;
        end
      end
      S_SCORE: begin
        // r_score already holds the incremented value while in SCORE.
        if (r_score == SCORE_MAX) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt == RECOVER_LAST) begin
          w_next = S_REST;
        end
      end
      S_DONE: begin
        if (new_bout_in) begin
          w_next = S_REST;
        end
      end
      default: begin
        w_next = S_REST;
      end
    endcase
  end

  // Dwell counter: cleared on any state change, advances only in the timed states.
  always_comb begin
    w_counting = (r_state == S_LUNGE) || (r_state == S_ATTACK) || (r_state == S_RECOVER);
    w_cnt_next = r_cnt;
    if (w_next != r_state) begin
      w_cnt_next = '0;
    end else if (w_counting) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Score bumps on the edge into SCORE so the new value appears alongside the pulse.
  always_comb begin
    w_score_next = r_score;
    if ((r_state == S_DONE) && new_bout_in) begin
      w_score_next = '0;
    end else if ((w_next == S_SCORE) && (r_state != S_SCORE) && (r_score != SCORE_MAX)) begin
      w_score_next = r_score + 1'b1;
    end
  end

  // State, counter, score and decoded outputs, all registered from the next-state value.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_state       <= S_REST;
      r_cnt         <= '0;
      r_score       <= '0;
      r_in_attack   <= 1'b0;
      r_score_pulse <= 1'b0;
      r_bout_over   <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_score       <= w_score_next;
      r_in_attack   <= (w_next == S_ATTACK);
      r_score_pulse <= (w_next == S_SCORE);
      r_bout_over   <= (w_next == S_DONE);
    end
  end

  assign state_out       = r_state;
  assign in_attack_out   = r_in_attack;
  assign score_out       = r_score;
  assign score_pulse_out = r_score_pulse;
  assign bout_over_out   = r_bout_over;

endmodule

// File: tb/tb_fencer_action_sequencer.sv
// Directed bench for fencer_action_sequencer (MAX_SCORE=2, other parameters default).
// Stimulus pushes the hand-computed post-edge outputs; a monitor pops one entry per clock and compares.
// Bits of the stimulus word: block, lunge, hit, clash, opp_hit, new_bout, reset.
module tb_fencer_action_sequencer;

  localparam int B = 1;
  localparam int L = 2;
  localparam int H = 4;
  localparam int C = 8;
  localparam int O = 16;
  localparam int N = 32;
  localparam int R = 64;

  logic       clk_pixel_in;
  logic       rst_in;
  logic       block_in;
  logic       lunge_in;
  logic       hit_in;
  logic       clash_in;
  logic       opp_hit_in;
  logic       new_bout_in;
  logic [2:0] state_out;
  logic       in_attack_out;
  logic [3:0] score_out;
  logic       score_pulse_out;
  logic       bout_over_out;

  fencer_action_sequencer #(
    .LUNGE_CYCLES  (4),
    .ATTACK_CYCLES (16),
    .RECOVER_CYCLES(32),
    .MAX_SCORE     (2),
    .SCORE_W       (4)
  ) dut (
    .clk_pixel_in   (clk_pixel_in),
    .rst_in         (rst_in),
    .block_in       (block_in),
    .lunge_in       (lunge_in),
    .hit_in         (hit_in),
    .clash_in       (clash_in),
    .opp_hit_in     (opp_hit_in),
    .new_bout_in    (new_bout_in),
    .state_out      (state_out),
    .in_attack_out  (in_attack_out),
    .score_out      (score_out),
    .score_pulse_out(score_pulse_out),
    .bout_over_out  (bout_over_out)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sc;
    logic       pulse;
    logic       atk;
    logic       over;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;
  int    sc     = 0;

  initial clk_pixel_in = 1'b0;
  always #5 clk_pixel_in = ~clk_pixel_in;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input int ins, input int st, input int pulse, input string nm);
    exp_t e;
    @(negedge clk_pixel_in);
    block_in    = (ins & B) != 0;
    lunge_in    = (ins & L) != 0;
    hit_in      = (ins & H) != 0;
    clash_in    = (ins & C) != 0;
    opp_hit_in  = (ins & O) != 0;
    new_bout_in = (ins & N) != 0;
    rst_in      = (ins & R) != 0;
    e.st    = 3'(st);
    e.sc    = 4'(sc);
    e.pulse = (pulse != 0);
    e.atk   = (st == 3);
    e.over  = (st == 6);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic run(input int n, input int ins, input int st, input string nm);
    for (int i = 0; i < n; i++) step(ins, st, 0, nm);
  endtask

  // Monitor: one sample per clock, away from the edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk_pixel_in);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (state_out !== e.st || score_out !== e.sc || score_pulse_out !== e.pulse ||
            in_attack_out !== e.atk || bout_over_out !== e.over) begin
          fails++;
          $display("FAIL %s: got st=%0d sc=%0d pulse=%0b atk=%0b over=%0b, want st=%0d sc=%0d pulse=%0b atk=%0b over=%0b",
                   nm, state_out, score_out, score_pulse_out, in_attack_out, bout_over_out,
                   e.st, e.sc, e.pulse, e.atk, e.over);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b1; block_in = 1'b0; lunge_in = 1'b0; hit_in = 1'b0;
    clash_in = 1'b0; opp_hit_in = 1'b0; new_bout_in = 1'b0;

    step(R, 0, 0, "reset0");
    step(R, 0, 0, "reset1");
    step(O, 0, 0, "rest_opp_ignored");

    // Plain lunge, timeout, recover; lunge_in held during LUNGE is ignored.
    step(L, 2, 0, "t1_lunge");
    run(3, L, 2, "t1_lunge_dwell");
    run(16, 0, 3, "t1_attack");
    run(32, 0, 5, "t1_recover");
    step(0, 0, 0, "t1_rest");

    // Hit and clash together on the 3rd ATTACK cycle: hit wins.
    step(L, 2, 0, "t2_lunge");
    run(3, 0, 2, "t2_lunge_dwell");
    run(3, 0, 3, "t2_attack");
    sc = 1;
    step(H | C, 4, 1, "t2_score");
    run(32, 0, 5, "t2_recover");
    step(0, 0, 0, "t2_rest");

    // Second point reaches MAX_SCORE=2 -> DONE; everything but new_bout ignored.
    step(L, 2, 0, "t3_lunge");
    run(3, 0, 2, "t3_lunge_dwell");
    run(1, 0, 3, "t3_attack");
    sc = 2;
    step(H, 4, 1, "t3_score_max");
    step(0, 6, 0, "t3_done");
    step(L, 6, 0, "t3_lunge_ignored");
    step(B | H | C | O, 6, 0, "t3_others_ignored");
    sc = 0;
    step(N, 0, 0, "t3_new_bout");
    step(0, 0, 0, "t3_rest");

    // Block priority, opponent hit during BLOCK, gestures ignored in RECOVER.
    step(B | L, 1, 0, "t4_block_prio");
    step(B, 1, 0, "t4_block_hold");
    step(B | O, 5, 0, "t4_opp_hit");
    run(31, B | L, 5, "t4_recover_ignore");
    step(B, 0, 0, "t4_rest_after_recover");
    step(B, 1, 0, "t4_reblock");

    // Clash while blocking.
`ifdef FENCE_RIPOSTE_EN
    step(B | C, 3, 0, "t5_riposte");
    step(O, 5, 0, "t5_opp_hit_attack");
    run(31, 0, 5, "t5_recover");
    step(0, 0, 0, "t5_rest");
`else
    step(B | C, 1, 0, "t5_clash_ignored");
    step(0, 0, 0, "t5_release");
`endif

    // Clash alone ends an attack without scoring.
    step(L, 2, 0, "t7_lunge");
    run(3, 0, 2, "t7_lunge_dwell");
    run(1, 0, 3, "t7_attack");
    step(C, 5, 0, "t7_clash");
    run(31, 0, 5, "t7_recover");
    step(0, 0, 0, "t7_rest");

    // Hit on the final ATTACK cycle still scores.
    step(L, 2, 0, "t8_lunge");
    run(3, 0, 2, "t8_lunge_dwell");
    run(16, 0, 3, "t8_attack_full");
    sc = 1;
    step(H, 4, 1, "t8_hit_last_cycle");
    run(32, 0, 5, "t8_recover");
    step(0, 0, 0, "t8_rest");

    // Reset mid-ATTACK with score 1.
    step(L, 2, 0, "t6_lunge");
    run(3, 0, 2, "t6_lunge_dwell");
    run(2, 0, 3, "t6_attack");
    sc = 0;
    step(R, 0, 0, "t6_reset_mid_attack");
    step(0, 0, 0, "t6_after_reset");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_pixel_in);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expected samples left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
